// File: rtl/halfdup_pkg.sv
// Shared definitions for the half-duplex bit-serial controller:
// state encodings and counter-width helper.
package halfdup_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/halfdup_bit_ctrl_tick.sv
// Bit-rate divider: registered tick pulse once every CLKDIV cycles while run=1.
// run is the controller's next-cycle busy, so the first tick lands CLKDIV cycles after accept.
module bit_tick_gen
  import halfdup_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic tick
);

  localparam int CW = (clog2(CLKDIV) < 1) ? 1 : clog2(CLKDIV);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  // div_cnt holds the phase of the upcoming cycle, which lets tick itself be a flop
  logic [CW-1:0] div_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/halfdup_bit_ctrl.sv
// Half-duplex bit-serial transaction controller driving a registered pad buffer:
// MSB-first DW-bit write serialisation or DW-bit read deserialisation, DW+1 bit ticks each.
module halfdup_bit_ctrl
  import halfdup_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CLKDIV = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          rd,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          pad_i,
  output logic          pad_en,
  output logic          pad_ce,
  input  logic          pad_o
);

  localparam int BW = clog2(DW + 2);

  state_t          state_reg;
  state_t          state_next;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   sr;
  logic            accept;
  logic            last_tick;
  logic            run;

  assign accept    = start && !busy;
  assign last_tick = pad_ce && (bit_cnt == BW'(DW));
  assign run       = (state_next == ST_WRITE) || (state_next == ST_READ);

  bit_tick_gen #(.CLKDIV(CLKDIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .run  (run),
    .tick (pad_ce)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: state_next = accept ? (rd ? ST_READ : ST_WRITE) : ST_IDLE;
      ST_WRITE, ST_READ: if (last_tick) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      pad_i     <= 1'b0;
      pad_en    <= 1'b0;
      bit_cnt   <= '0;
      sr        <= '0;
    end else begin
      state_reg <= state_next;
      busy      <= run;
      done      <= (state_next == ST_DONE);
      if (accept) begin
        bit_cnt <= '0;
        sr      <= rd ? '0 : wdata;
        pad_i   <= rd ? 1'b0 : wdata[DW-1];
        pad_en  <= !rd;
      end else if (pad_ce) begin
        bit_cnt <= bit_cnt + BW'(1);
        if (state_reg == ST_WRITE) begin
          // The LSB stays presented through ticks DW and DW+1
          if (bit_cnt < BW'(DW - 1)) begin
            sr    <= sr << 1;
            pad_i <= sr[DW-2];
          end
          if (last_tick) begin
            pad_en <= 1'b0;
            pad_i  <= 1'b0;
          end
        end else if (state_reg == ST_READ) begin
          // pad_o on tick 1 predates the first sample of this transaction
          if (bit_cnt != '0) sr <= {sr[DW-2:0], pad_o};
          if (last_tick) rdata <= {sr[DW-2:0], pad_o};
        end
      end
    end
  end

endmodule

// File: tb/tb_halfdup_bit_ctrl.sv
// Self-checking bench: directed scenarios plus random transactions against a
// transaction-level expectation model and a registered pad buffer / wire model.
module tb_halfdup_bit_ctrl;

  localparam int DW = 8;
  localparam int CD = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          start = 1'b0, rd = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, pad_i, pad_en, pad_ce;
  logic [DW-1:0] rdata;
  logic          pad_o = 1'b0;

  logic          start_f = 1'b0, rd_f = 1'b0;
  logic [DW-1:0] wdata_f = '0;
  logic          busy_f, done_f, pad_i_f, pad_en_f, pad_ce_f;
  logic [DW-1:0] rdata_f;
  logic          pad_o_f = 1'b0;

  halfdup_bit_ctrl #(.DW(DW), .CLKDIV(CD)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rd(rd), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .pad_i(pad_i), .pad_en(pad_en), .pad_ce(pad_ce), .pad_o(pad_o)
  );

  halfdup_bit_ctrl #(.DW(DW), .CLKDIV(1)) dut_f (
    .CLK(CLK), .RST(RST), .start(start_f), .rd(rd_f), .wdata(wdata_f),
    .busy(busy_f), .done(done_f), .rdata(rdata_f),
    .pad_i(pad_i_f), .pad_en(pad_en_f), .pad_ce(pad_ce_f), .pad_o(pad_o_f)
  );

  // Remote device presents word MSB-first, one bit per pad sample
  logic [DW-1:0] wire_word = '0, wire_word_f = '0;
  int nticks = 0, nticks_f = 0;

  function automatic logic ext_bit(input logic [DW-1:0] w, input int n);
    return (n < DW) ? w[DW-1-n] : 1'b0;
  endfunction

  always @(posedge CLK) begin
    if (!busy) nticks <= 0;
    else if (pad_ce) nticks <= nticks + 1;
    if (pad_ce) pad_o <= pad_en ? pad_i : ext_bit(wire_word, nticks);
    if (!busy_f) nticks_f <= 0;
    else if (pad_ce_f) nticks_f <= nticks_f + 1;
    if (pad_ce_f) pad_o_f <= pad_en_f ? pad_i_f : ext_bit(wire_word_f, nticks_f);
  end

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input bit is_rd, input logic [DW-1:0] word);
    int g = 0;
    while (busy && g < 200) begin
      @(negedge CLK);
      g++;
    end
    start     = 1'b1;
    rd        = is_rd;
    wdata     = is_rd ? DW'($urandom) : word;
    wire_word = word;
    @(negedge CLK);
    start = 1'b0;
    rd    = 1'($urandom);
    wdata = DW'($urandom);
  endtask

  // Called at the negedge of the first cycle after accept; returns at the done cycle
  task automatic follow(input bit is_rd, input logic [DW-1:0] word, input bit glitch, input string tag);
    int cyc = 1, ticks = 0, en_cycles = 0, first_tick = 0, done_cyc = 0;
    logic [DW-1:0] sent = '0;
    bit pi_any = 0, finished = 0;
    while (!finished && cyc <= 200) begin
      if (glitch) start = (cyc == 3 * CD) || (cyc == 6 * CD);
      if (pad_en) en_cycles++;
      if (pad_i) pi_any = 1;
      if (pad_ce) begin
        ticks++;
        if (ticks == 1) first_tick = cyc;
        if (ticks <= DW) sent = {sent[DW-2:0], pad_i};
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    if (glitch) start = 1'b0;
    chk({tag, " done_cycle"}, done_cyc, (DW + 1) * CD + 1);
    chk({tag, " tick_count"}, ticks, DW + 1);
    chk({tag, " first_tick"}, first_tick, CD);
    chk({tag, " busy_at_done"}, 32'(busy), 0);
    chk({tag, " pad_en_at_done"}, 32'(pad_en), 0);
    if (!is_rd) begin
      chk({tag, " serial_bits"}, sent, word);
      chk({tag, " pad_en_cycles"}, en_cycles, (DW + 1) * CD);
      chk({tag, " rdata_kept"}, rdata, exp_rdata);
    end else begin
      chk({tag, " pad_en_cycles"}, en_cycles, 0);
      chk({tag, " pad_i_low"}, 32'(pi_any), 0);
      chk({tag, " rdata"}, rdata, word);
      exp_rdata = word;
    end
    txn++;
    $display("txn %0d %s rd=%0b word=0x%02h ticks=%0d done_cycle=%0d rdata=0x%02h",
             txn, tag, is_rd, word, ticks, done_cyc, rdata);
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    chk({tag, " single_done"}, 32'(done), 0);
    chk({tag, " idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset rdata", rdata, 0);
    chk("reset pad_i", 32'(pad_i), 0);
    chk("reset pad_en", 32'(pad_en), 0);
    chk("reset pad_ce", 32'(pad_ce), 0);
    RST = 1'b0;
    @(negedge CLK);

    launch(1'b0, 8'hA5);
    follow(1'b0, 8'hA5, 1'b0, "t1_write");
    idle_check("t1");

    launch(1'b1, 8'h3C);
    follow(1'b1, 8'h3C, 1'b0, "t2_read");
    idle_check("t2");

    // start held high across a write and straight into a read
    start = 1'b1; rd = 1'b0; wdata = 8'hFF; wire_word = 8'h5A;
    @(negedge CLK);
    rd = 1'b1; wdata = DW'($urandom);
    follow(1'b0, 8'hFF, 1'b0, "t3_write");
    @(negedge CLK);
    chk("t3 no_idle_gap", 32'(busy), 1);
    start = 1'b0;
    follow(1'b1, 8'h5A, 1'b0, "t3_read");
    idle_check("t3");

    launch(1'b0, 8'h6E);
    follow(1'b0, 8'h6E, 1'b1, "t4_write_glitch");
    idle_check("t4");

    // reset in the middle of a write
    begin
      int t = 0, g = 0;
      launch(1'b0, 8'h81);
      while (t < 4 && g < 100) begin
        if (pad_ce) t++;
        @(negedge CLK);
        g++;
      end
      chk("t5 reached_tick4", t, 4);
      RST = 1'b1;
      #1;
      chk("t5 rst pad_en", 32'(pad_en), 0);
      chk("t5 rst busy", 32'(busy), 0);
      chk("t5 rst pad_ce", 32'(pad_ce), 0);
      chk("t5 rst rdata", rdata, 0);
      exp_rdata = '0;
      repeat (2) begin
        @(negedge CLK);
        chk("t5 rst no_done", 32'(done), 0);
      end
      RST = 1'b0;
      @(negedge CLK);
      launch(1'b0, 8'h81);
      follow(1'b0, 8'h81, 1'b0, "t5_write_after_rst");
      idle_check("t5");
    end

    for (int i = 0; i < 12; i++) begin
      bit r;
      bit gl;
      logic [DW-1:0] w;
      r  = 1'($urandom);
      gl = 1'($urandom);
      w  = DW'($urandom);
      launch(r, w);
      follow(r, w, gl, r ? "rand_read" : "rand_write");
      idle_check("rand");
    end

    // CLKDIV=1 instance: one tick per busy cycle
    begin
      int ce_cnt = 0, done_cyc = 0;
      start_f = 1'b1; rd_f = 1'b1; wire_word_f = 8'h96;
      @(negedge CLK);
      start_f = 1'b0; rd_f = 1'b0;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
        if (pad_ce_f) ce_cnt++;
        if (done_f) done_cyc = c;
        else @(negedge CLK);
      end
      chk("t6 ce_cycles", ce_cnt, DW + 1);
      chk("t6 done_cycle", done_cyc, DW + 2);
      chk("t6 rdata", rdata_f, 8'h96);
      chk("t6 pad_en", 32'(pad_en_f), 0);
      txn++;
      $display("txn %0d t6_read_div1 word=0x96 ticks=%0d done_cycle=%0d rdata=0x%02h",
               txn, ce_cnt, done_cyc, rdata_f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
